// File: rtl/manchester_pkg.sv
// Shared types and threshold arithmetic for the Manchester receive front end.
package manchester_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned REF_MIN = 2;
    localparam int unsigned THR_W   = 8;

    // Half-bit setting actually used: 0 and 1 behave as the minimum.
    function automatic logic [3:0] eff_ref(input logic [3:0] refVal);
        return (refVal < 4'(REF_MIN)) ? 4'(REF_MIN) : refVal;
    endfunction

    function automatic logic [THR_W-1:0] mid_thr(input logic [3:0] refVal);
        return THR_W'(refVal) + THR_W'(refVal[3:1]);
    endfunction

    function automatic logic [THR_W-1:0] timeout(input logic [3:0] refVal);
        return THR_W'(refVal) + THR_W'({refVal, 1'b0});
    endfunction

endpackage

// File: rtl/manchester_decoder_edge_sync.sv
// Line synchronizer and edge detector: s is the synchronized level, lineEdge flags any transition.
module edge_sync
    import manchester_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic globalReset,
    input  logic lineIn,
    output logic s,
    output logic lineEdge
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   p;

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            syncReg <= '0;
            p       <= 1'b0;
        end else begin
            syncReg[0] <= lineIn;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                syncReg[i] <= syncReg[i-1];
            end
            p <= syncReg[SYNC_STAGES-1];
        end
    end

    assign s        = syncReg[SYNC_STAGES-1];
    assign lineEdge = s ^ p;

endmodule

// File: rtl/manchester_decoder.sv
// Oversampling Manchester decoder: recovers NRZ data, a data-qualified bit clock
// and a free-running balanced bit clock from the synchronized line.
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int unsigned CW          = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       globalReset,
    input  logic       ManchesterCode,
    input  logic [3:0] REF,
    output logic       recoveredData,
    output logic       recoveredCLK,
    output logic       balancedCLK
);

    localparam int unsigned CMP_W = (CW > THR_W) ? CW : THR_W;

    logic             s;
    logic             lineEdge;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       phase;
    logic [3:0]       refEff;
    logic [CMP_W-1:0] cntX;
    logic [CMP_W-1:0] midX;
    logic [CMP_W-1:0] toX;
    logic             accept;
    logic             timedOut;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) uSync (
        .clk        (clk),
        .globalReset(globalReset),
        .lineIn     (ManchesterCode),
        .s          (s),
        .lineEdge   (lineEdge)
    );

    always_comb begin
        refEff   = eff_ref(REF);
        cntX     = CMP_W'(cnt);
        midX     = CMP_W'(mid_thr(refEff));
        toX      = CMP_W'(timeout(refEff));
        accept   = lineEdge && ((state == HUNT) || (cntX >= midX));
        timedOut = (state == LOCKED) && (cntX >= toX);
    end

    // phase == 0 marks "never locked since reset"; the flywheel stays parked until then.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            state         <= HUNT;
            cnt           <= '0;
            phase         <= '0;
            recoveredData <= 1'b0;
            recoveredCLK  <= 1'b0;
            balancedCLK   <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= CW'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                state         <= LOCKED;
                recoveredData <= ~s;
                recoveredCLK  <= 1'b1;
                balancedCLK   <= 1'b1;
                phase         <= 4'd1;
            end else begin
                if (timedOut) begin
                    state <= HUNT;
                end
                if (phase != '0) begin
                    if (phase >= refEff) begin
                        phase        <= 4'd1;
                        balancedCLK  <= ~balancedCLK;
                        recoveredCLK <= 1'b0;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                if ((state == HUNT) || timedOut) begin
                    recoveredCLK <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed bench for manchester_decoder: segment tables of line levels with expected outputs.
module tb_manchester_decoder;
    import manchester_pkg::*;

    logic       clk = 1'b0;
    logic       globalReset;
    logic       ManchesterCode;
    logic [3:0] REF;
    logic       recoveredData;
    logic       recoveredCLK;
    logic       balancedCLK;

    always #5 clk = ~clk;

    manchester_decoder #(
        .CW         (6),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .globalReset   (globalReset),
        .ManchesterCode(ManchesterCode),
        .REF           (REF),
        .recoveredData (recoveredData),
        .recoveredCLK  (recoveredCLK),
        .balancedCLK   (balancedCLK)
    );

    typedef struct {
        logic        lvl;
        int unsigned len;
        logic        chkMid;
        logic        eData;
        logic        eRec;
        logic        eBal;
        logic        chkLock;
    } seg_t;

    seg_t        dec[$];
    seg_t        jit[$];
    seg_t        ref2[$];
    seg_t        segs[$];
    logic        gotBits[$];
    logic        expBits[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned width = 0;
    int unsigned expWidth = 8;
    int unsigned pulses = 0;
    int unsigned lastEdgeCyc = 0;
    int          latIdx = -1;
    logic        prevRec = 1'b0;
    logic        mon = 1'b0;

    function automatic seg_t mk(input logic lvl, input int unsigned len, input logic chkMid,
                                input logic d, input logic r, input logic b, input logic lk);
        seg_t x;
        x.lvl = lvl; x.len = len; x.chkMid = chkMid;
        x.eData = d; x.eRec = r; x.eBal = b; x.chkLock = lk;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled on the falling edge, before any new drive.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mon) begin
            if (recoveredCLK && !prevRec) begin
                pulses++;
                width = 1;
            end else if (recoveredCLK) begin
                width++;
            end else if (prevRec) begin
                gotBits.push_back(recoveredData);
                chk("pulseWidth", width, expWidth);
            end
        end
        prevRec = recoveredCLK;
    endtask

    task automatic runSegs(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if (segs[k].lvl !== ManchesterCode) lastEdgeCyc = cyc;
            ManchesterCode = segs[k].lvl;
            for (int unsigned i = 1; i <= segs[k].len; i++) begin
                step();
                if (i == 2 && k == latIdx) begin
                    chk("latRecEarly", recoveredCLK, 1'b0);
                    chk("latBalEarly", balancedCLK, 1'b0);
                end
                if (i == 3 && segs[k].chkMid) begin
                    chk("segData", recoveredData, segs[k].eData);
                    chk("segRec", recoveredCLK, segs[k].eRec);
                    chk("segBal", balancedCLK, segs[k].eBal);
                end
            end
            if (segs[k].chkLock) chk("locked", 32'(dut.state), 32'(LOCKED));
        end
    endtask

    task automatic checkBits(input string tag);
        logic got;
        chk({tag, "BitCount"}, gotBits.size(), 8);
        chk({tag, "Pulses"}, pulses, 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < gotBits.size()) ? gotBits[i] : 1'bx;
            chk({tag, "Bit"}, got, expBits[i]);
        end
    endtask

    task automatic doReset();
        mon = 1'b0;
        globalReset = 1'b0;
        ManchesterCode = 1'b0;
        repeat (3) step();
        globalReset = 1'b1;
        step();
        gotBits.delete();
        pulses = 0;
    endtask

    initial begin
        dec.push_back(mk(1'b0, 24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        dec.push_back(mk(1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b0,  8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b1,  8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        dec.push_back(mk(1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b1,  8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b0,  8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        dec.push_back(mk(1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
        dec.push_back(mk(1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

        jit.push_back(mk(1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        jit.push_back(mk(1'b1,  9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b0,  9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        jit.push_back(mk(1'b0,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        ref2.push_back(mk(1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        ref2.push_back(mk(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref2.push_back(mk(1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset held with the line toggling, then idle after release.
        REF = 4'd8;
        globalReset = 1'b0;
        ManchesterCode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ManchesterCode = ~ManchesterCode;
            step();
        end
        chk("rstData", recoveredData, 1'b0);
        chk("rstRec", recoveredCLK, 1'b0);
        chk("rstBal", balancedCLK, 1'b0);
        chk("rstState", 32'(dut.state), 32'(HUNT));
        globalReset = 1'b1;
        ManchesterCode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("idleOut", {recoveredCLK, balancedCLK, recoveredData}, 3'b000);
        end

        // Decode at REF=8, including sync-edge latency.
        gotBits.delete();
        pulses = 0;
        expWidth = 8;
        latIdx = 1;
        mon = 1'b1;
        segs = dec;
        runSegs(0, 10);

        // Flywheel and loss of lock after the last accepted edge.
        while (cyc < lastEdgeCyc + 45) begin
            int unsigned k;
            step();
            k = cyc - lastEdgeCyc - 3;
            chk("flyBal", balancedCLK, ((k / 8) % 2) == 0);
            chk("flyRec", recoveredCLK, 1'b0);
            if (cyc == lastEdgeCyc + 26) chk("preTimeout", 32'(dut.state), 32'(LOCKED));
            if (cyc == lastEdgeCyc + 27) chk("timeoutHunt", 32'(dut.state), 32'(HUNT));
        end
        checkBits("dec");

        // Asynchronous reset after the third decoded bit, then relock.
        doReset();
        REF = 4'd8;
        latIdx = -1;
        mon = 1'b1;
        segs = dec;
        runSegs(0, 3);
        ManchesterCode = 1'b0;
        repeat (5) step();
        chk("midBit3", recoveredData, 1'b1);
        chk("midRecHigh", recoveredCLK, 1'b1);
        chk("midBitsSoFar", gotBits.size(), 2);
        mon = 1'b0;
        #2 globalReset = 1'b0;
        #1;
        chk("asyncData", recoveredData, 1'b0);
        chk("asyncRec", recoveredCLK, 1'b0);
        chk("asyncBal", balancedCLK, 1'b0);
        chk("asyncState", 32'(dut.state), 32'(HUNT));
        step();
        step();
        globalReset = 1'b1;
        gotBits.delete();
        pulses = 0;
        latIdx = 1;
        mon = 1'b1;
        runSegs(0, 10);
        checkBits("relock");

        // REF=4 with mid-bit edges shifted by one cycle.
        doReset();
        REF = 4'd4;
        expWidth = 4;
        latIdx = -1;
        mon = 1'b1;
        segs = jit;
        runSegs(0, 10);
        checkBits("jit");

        // REF=0 must behave as REF=2.
        doReset();
        REF = 4'd0;
        expWidth = 2;
        mon = 1'b1;
        segs = ref2;
        runSegs(0, 10);
        checkBits("ref0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_decoder.md
Name: manchester_decoder

Overview:
- Recovers NRZ data and a bit-rate clock from a Manchester-coded serial line, using oversampling on the system clock `clk`.
- Half-bit length in `clk` cycles is set at runtime by `REF`. The front end of the LED-control receive path feeds the recovered data and clock to the downstream deserializer.
- Line coding: a rising mid-bit transition encodes 0, a falling mid-bit transition encodes 1. The line idles low, and every frame starts with a 0 sync bit.

Parameters:
- CW, 6, width of the edge-interval counter. Must hold 4*15; the counter saturates at all-ones.
- SYNC_STAGES, 2, number of input synchronizer flops on `ManchesterCode`.

Ports:
- `clk`  in  1  system oversampling clock; all logic on its rising edge.
- `globalReset`  in  1  asynchronous, active-low reset.
- `ManchesterCode`  in  1  asynchronous Manchester line input.
- `REF`  in  4  half-bit period in `clk` cycles. Valid range 2..15; values 0 and 1 are treated as 2.
- `recoveredData`  out  1  decoded bit, held for one bit period.
- `recoveredCLK`  out  1  data-qualified bit clock; pulses only while locked.
- `balancedCLK`  out  1  50%-duty flywheel bit clock, realigned at each mid-bit edge.

Behaviour:
- Reset (`globalReset`=0): synchronizer flops and previous-level flop go to 0. The following are all 0: `cnt`, `phase`, `recoveredData`, `recoveredCLK`, `balancedCLK`. State goes to HUNT. Reset mid-frame aborts immediately.
- Input path:
  - `ManchesterCode` passes through SYNC_STAGES flops, giving `s`, then a previous-level flop `p`.
  - `edge = s ^ p`.
  - All outputs are registered, so an output reacts 3 `clk` cycles after the input change is first sampled.
- Counter `cnt`: counts cycles since the last accepted mid-bit edge. It saturates and does not wrap. It resets to 1 on an accepted edge.
- States:
  - HUNT: the first edge of either polarity is accepted as a mid-bit edge, then go to LOCKED.
  - LOCKED:
    - An edge with `cnt` >= `REF` + `REF`/2 is a mid-bit edge and is accepted.
    - An edge with `cnt` below that is a bit-boundary edge; it is ignored and `cnt` keeps counting.
    - If `cnt` reaches 3*`REF` without an accepted edge, go to HUNT (loss of lock).
- On an accepted edge:
  - `recoveredData` <= ~`s` (rising edge gives 0, falling gives 1).
  - `recoveredCLK` <= 1, `balancedCLK` <= 1, `phase` <= 1.
- `recoveredCLK`:
  - While LOCKED, it falls when `phase` reaches `REF` and stays low until the next accepted edge.
  - It is forced 0 in HUNT.
  - Downstream samples `recoveredData` on the falling edge of `recoveredCLK`.
- `balancedCLK`:
  - Toggles each time `phase` reaches `REF`; `phase` then restarts at 1. It free-runs in both states once first locked.
  - It stays 0 from reset until the first accepted edge.
- `recoveredData` holds its last value through HUNT.
- Simultaneous events:
  - An accepted edge overrides the `phase`/`REF` toggle in the same cycle.
  - An edge arriving in the cycle `cnt` hits the timeout is accepted; the edge wins.
- `REF` is sampled live, with no latching; a change takes effect on the next comparison.
- Arithmetic is unsigned, zero-extended to CW bits. The `REF`/2 term uses truncating division.

Decomposition:
- Shared package `manchester_pkg` contains:
  - state enum {HUNT, LOCKED};
  - `REF_MIN`=2;
  - the threshold formulas as functions: `mid_thr(REF)` = REF + REF/2 and `timeout(REF)` = 3*REF.
- One natural sub-module, `edge_sync`: synchronizer plus edge detector, outputting `s` and `edge`. The counter, FSM and clock generation stay in the top module.

Test Plan:
- Reset: hold `globalReset`=0 with line toggling → all outputs 0 and state HUNT. Release with the line low and idle for 40 cycles → outputs remain 0.
- Decode, `REF`=8:
  - Stimulus: idle low 24 cycles, then high 16, low 8, high 8, low 16, high 16, low 16, high 8, low 8, high 16, low 16.
  - Required `recoveredData` bits at accepted edges: 0,1,1,0,1,0,0,1.
  - Boundary edges at 8-cycle spacing are ignored.
  - `recoveredCLK` shows exactly 8 high pulses, each 8 cycles wide.
- Latency: one sync edge with `REF`=8 → `recoveredCLK` and `balancedCLK` rise exactly 3 cycles after the input transition.
- Flywheel/timeout: after the last bit the line stays low → state returns to HUNT 24 cycles after the last accepted edge. `recoveredCLK` stays 0 while `balancedCLK` keeps toggling every 8 cycles.
- Jitter and `REF` range:
  - With `REF`=4, shift mid-bit edges ±1 cycle → same bit sequence, no false lock loss.
  - With `REF`=0, the block behaves as `REF`=2.
- Asynchronous reset mid-frame: assert reset after the 3rd decoded bit → outputs clear immediately. The next sync 0 relocks and decodes correctly.
